// File: rtl/set_ui_controller.sv
// Set-mode user interface: synchronizes and debounces MODE/INC buttons, runs the
// RUN/SET_* state machine, and emits single-cycle field-increment pulses with auto-repeat.
module set_ui_controller #(
    parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000,
    parameter int unsigned TIMEOUT_CYCLES      = 500000000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       btn_mode_raw,
    input  logic       btn_inc_raw,
    output logic       inc_hours_ui,
    output logic       inc_minutes_ui,
    output logic       inc_seconds_ui,
    output logic [1:0] set_mode,
    output logic       set_active
);

    localparam int unsigned NBTN     = 2;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned REP_MAX  = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                       REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_W    = $clog2(REP_MAX + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST         = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST   = REP_W'(REPEAT_RATE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST         = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HOURS   = 2'b01,
        ST_MINUTES = 2'b10,
        ST_SECONDS = 2'b11
    } state_t;

    logic [NBTN-1:0] sync_a;
    logic [NBTN-1:0] sync_b;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] stable_q;
    logic [DB_W-1:0] db_cnt [NBTN];

    // Two-flop synchronizers, per-button debounce counters and edge history.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a   <= '0;
            sync_b   <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a   <= {btn_inc_raw, btn_mode_raw};
            sync_b   <= sync_a;
            stable_q <= stable;
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (sync_b[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic press_mode_c;
    logic press_inc_c;
    logic inc_held_c;

    assign press_mode_c = stable[BTN_MODE] & ~stable_q[BTN_MODE];
    assign press_inc_c  = stable[BTN_INC] & ~stable_q[BTN_INC];
    assign inc_held_c   = stable[BTN_INC];

    state_t           state_q, state_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;
    logic             rep_first_q, rep_first_d;
    logic             inc_hours_d, inc_minutes_d, inc_seconds_d;
    logic             set_active_d;
    logic             fire_c;

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            idle_q         <= '0;
            rep_cnt_q      <= '0;
            rep_armed_q    <= 1'b0;
            rep_first_q    <= 1'b0;
            inc_hours_ui   <= 1'b0;
            inc_minutes_ui <= 1'b0;
            inc_seconds_ui <= 1'b0;
            set_active     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_q         <= idle_d;
            rep_cnt_q      <= rep_cnt_d;
            rep_armed_q    <= rep_armed_d;
            rep_first_q    <= rep_first_d;
            inc_hours_ui   <= inc_hours_d;
            inc_minutes_ui <= inc_minutes_d;
            inc_seconds_ui <= inc_seconds_d;
            set_active     <= set_active_d;
        end
    end

    // Next state: MODE press has priority over INC; repeat stays disarmed until a fresh INC press.
    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_first_d = rep_first_q;
        fire_c      = 1'b0;

        if (state_q == ST_RUN) begin
            idle_d      = '0;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
            if (press_mode_c) begin
                state_d = ST_HOURS;
            end
        end else if (press_mode_c) begin
            state_d     = state_t'(state_q + 2'd1);
            idle_d      = '0;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else begin
            if (press_inc_c) begin
                fire_c      = 1'b1;
                rep_armed_d = 1'b1;
                rep_first_d = 1'b1;
                rep_cnt_d   = '0;
            end else if (rep_armed_q && inc_held_c) begin
                if (rep_cnt_q == (rep_first_q ? REP_DELAY_LAST : REP_RATE_LAST)) begin
                    fire_c      = 1'b1;
                    rep_first_d = 1'b0;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end else begin
                rep_armed_d = 1'b0;
                rep_cnt_d   = '0;
            end

            if (press_inc_c || inc_held_c) begin
                idle_d = '0;
            end else if (idle_q == TO_LAST) begin
                state_d = ST_RUN;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + TO_W'(1);
            end
        end

        inc_hours_d   = fire_c && (state_q == ST_HOURS);
        inc_minutes_d = fire_c && (state_q == ST_MINUTES);
        inc_seconds_d = fire_c && (state_q == ST_SECONDS);
        set_active_d  = (state_d != ST_RUN);
    end

    assign set_mode = state_q;

endmodule

// File: tb/tb_set_ui_controller.sv
// Bench for set_ui_controller: timestamp-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_set_ui_controller;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RR = 5;
    localparam int unsigned TO = 100;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       btn_mode_raw;
    logic       btn_inc_raw;
    logic       inc_hours_ui;
    logic       inc_minutes_ui;
    logic       inc_seconds_ui;
    logic [1:0] set_mode;
    logic       set_active;

    int n_cmp = 0;
    int n_mis = 0;
    int cnt_h = 0;
    int cnt_m = 0;
    int cnt_s = 0;

    set_ui_controller #(
        .DEBOUNCE_CYCLES    (DB),
        .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_RATE_CYCLES (RR),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .btn_mode_raw  (btn_mode_raw),
        .btn_inc_raw   (btn_inc_raw),
        .inc_hours_ui  (inc_hours_ui),
        .inc_minutes_ui(inc_minutes_ui),
        .inc_seconds_ui(inc_seconds_ui),
        .set_mode      (set_mode),
        .set_active    (set_active)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: debounce as "D consecutive differing sync samples", repeat and timeout as timestamps.
    int          e;
    int          m_mode;
    bit          m_armed;
    int          next_fire;
    int          last_act;
    bit          m_h, m_m, m_s;
    logic [1:0]  m_st, m_pv;
    logic [31:0] rh [2];
    logic [DB-1:0] win;
    bit          pm, pi, fire, raw_b;

    initial begin
        forever begin
            @(posedge sys_clk or negedge rst_n);
            if (!rst_n) begin
                e = 0; m_mode = 0; m_armed = 0; next_fire = 0; last_act = 0;
                m_h = 0; m_m = 0; m_s = 0; m_st = '0; m_pv = '0;
                rh[0] = '0; rh[1] = '0;
            end else begin
                e++;
                pm = m_st[0] & ~m_pv[0];
                pi = m_st[1] & ~m_pv[1];
                fire = 0;
                m_h = 0; m_m = 0; m_s = 0;
                if (m_mode == 0) begin
                    m_armed = 0;
                    last_act = e;
                    if (pm) m_mode = 1;
                end else if (pm) begin
                    m_mode = (m_mode + 1) % 4;
                    m_armed = 0;
                    last_act = e;
                end else begin
                    if (pi) begin
                        fire = 1; m_armed = 1; next_fire = e + RD;
                    end else if (m_armed && m_st[1]) begin
                        if (e == next_fire) begin
                            fire = 1; next_fire = e + RR;
                        end
                    end else begin
                        m_armed = 0;
                    end
                    if (fire) begin
                        m_h = (m_mode == 1); m_m = (m_mode == 2); m_s = (m_mode == 3);
                    end
                    if (pi || m_st[1]) last_act = e;
                    else if (e - last_act >= TO) m_mode = 0;
                end
                m_pv = m_st;
                for (int b = 0; b < 2; b++) begin
                    win = rh[b][DB:1];
                    if ((m_st[b] == 1'b0) ? (&win) : (~|win)) m_st[b] = ~m_st[b];
                    raw_b = (b == 0) ? btn_mode_raw : btn_inc_raw;
                    rh[b] = {rh[b][30:0], raw_b};
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse counting.
    always @(negedge sys_clk) begin
        check("inc_hours_ui", int'(inc_hours_ui), int'(m_h));
        check("inc_minutes_ui", int'(inc_minutes_ui), int'(m_m));
        check("inc_seconds_ui", int'(inc_seconds_ui), int'(m_s));
        check("set_mode", int'(set_mode), m_mode);
        check("set_active", int'(set_active), int'(m_mode != 0));
        if (rst_n) begin
            cnt_h += int'(inc_hours_ui);
            cnt_m += int'(inc_minutes_ui);
            cnt_s += int'(inc_seconds_ui);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic press(input bit is_inc, input int hold);
        if (is_inc) btn_inc_raw = 1'b1; else btn_mode_raw = 1'b1;
        tick(hold);
        if (is_inc) btn_inc_raw = 1'b0; else btn_mode_raw = 1'b0;
        tick(12);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int h0, m0, s0;

    initial begin
        rst_n = 1'b0; btn_mode_raw = 1'b0; btn_inc_raw = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(50);
        check("idle set_mode", int'(set_mode), 0);
        check("idle outputs", int'({inc_hours_ui, inc_minutes_ui, inc_seconds_ui, set_active}), 0);

        // Bounce glitches of 3 cycles must not change state.
        for (int g = 0; g < 2; g++) begin
            btn_mode_raw = 1'b1; tick(3);
            btn_mode_raw = 1'b0; tick(3);
        end
        tick(8);
        check("glitch no change", int'(set_mode), 0);
        btn_mode_raw = 1'b1;
        tick(6);
        check("mode at k+5", int'(set_mode), 0);
        tick(1);
        check("mode at k+6", int'(set_mode), 1);
        check("active at k+6", int'(set_active), 1);
        tick(2);
        btn_mode_raw = 1'b0;
        tick(12);
        press(0, 8); check("mode seq 10", int'(set_mode), 2);
        press(0, 8); check("mode seq 11", int'(set_mode), 3);
        press(0, 8); check("mode seq 00", int'(set_mode), 0);

        // Asynchronous reset in SET_MINUTES.
        press(0, 8); press(0, 8);
        check("pre-reset mode", int'(set_mode), 2);
        @(posedge sys_clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset mode", int'(set_mode), 0);
        check("reset outputs", int'({inc_hours_ui, inc_minutes_ui, inc_seconds_ui, set_active}), 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // INC held 60 cycles in SET_MINUTES.
        press(0, 8); press(0, 8);
        check("enter minutes", int'(set_mode), 2);
        h0 = cnt_h; m0 = cnt_m; s0 = cnt_s;
        btn_inc_raw = 1'b1;
        tick(6);  check("inc k+5", int'(inc_minutes_ui), 0);
        tick(1);  check("inc k+6", int'(inc_minutes_ui), 1);
        tick(1);  check("inc k+7", int'(inc_minutes_ui), 0);
        tick(19); check("repeat k+26", int'(inc_minutes_ui), 1);
        tick(5);  check("repeat k+31", int'(inc_minutes_ui), 1);
        tick(28);
        btn_inc_raw = 1'b0;
        tick(12);
        check("minutes pulse count", cnt_m - m0, 9);
        check("hours stray", cnt_h - h0, 0);
        check("seconds stray", cnt_s - s0, 0);

        // INC in RUN is ignored.
        press(0, 8); press(0, 8);
        check("back to run", int'(set_mode), 0);
        h0 = cnt_h; m0 = cnt_m; s0 = cnt_s;
        press(1, 60);
        check("run inc pulses", (cnt_h - h0) + (cnt_m - m0) + (cnt_s - s0), 0);
        check("run mode", int'(set_mode), 0);

        // Simultaneous MODE and INC in SET_HOURS.
        press(0, 8);
        check("enter hours", int'(set_mode), 1);
        h0 = cnt_h; m0 = cnt_m; s0 = cnt_s;
        btn_mode_raw = 1'b1; btn_inc_raw = 1'b1;
        tick(10);
        btn_mode_raw = 1'b0; btn_inc_raw = 1'b0;
        tick(12);
        check("simul mode", int'(set_mode), 2);
        check("simul pulses", (cnt_h - h0) + (cnt_m - m0) + (cnt_s - s0), 0);
        press(1, 10);
        check("repress minutes", cnt_m - m0, 1);
        check("repress hours", cnt_h - h0, 0);

        // Timeout in SET_SECONDS with no activity.
        btn_mode_raw = 1'b1;
        tick(7);  check("enter seconds", int'(set_mode), 3);
        tick(1);  btn_mode_raw = 1'b0;
        tick(98); check("timeout e+99", int'(set_mode), 3);
        tick(1);  check("timeout e+100", int'(set_mode), 0);

        // Timeout restarted by an INC press 90 cycles after entering SET_SECONDS.
        press(0, 8); press(0, 8);
        s0 = cnt_s;
        btn_mode_raw = 1'b1;
        tick(7);  check("re-enter seconds", int'(set_mode), 3);
        tick(1);  btn_mode_raw = 1'b0;
        tick(82); btn_inc_raw = 1'b1;
        tick(6);  btn_inc_raw = 1'b0;
        tick(11); check("restart e+100", int'(set_mode), 3);
        tick(94); check("restart e+194", int'(set_mode), 3);
        tick(1);  check("restart e+195", int'(set_mode), 0);
        check("restart seconds pulse", cnt_s - s0, 1);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
